// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module     : if_stage_pkg
// Description: Shared constants and FSM state type for the MIPS
//              instruction-fetch stage.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

  // PC value loaded on reset unless the instance overrides it
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // All-zero word decodes as sll $0,$0,0, i.e. a nop bubble
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Byte distance between sequential instructions
  localparam logic [31:0] PC_STEP = 32'd4;

  // BOOT spends one cycle after reset without fetching, then RUN forever
  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module     : if_id_reg
// Description: IF/ID pipeline register. Clear (bubble) wins over load;
//              with neither asserted the contents hold.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        valid
);

  // Bubble on clear, capture on load, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst  <= NOP_INST;
      pc    <= 32'h0;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (clear) begin
      inst  <= NOP_INST;
      pc    <= 32'h0;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (load) begin
      inst  <= inst_in;
      pc    <= pc_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module     : if_stage
// Description: MIPS instruction-fetch stage. Owns the PC, addresses the
//              combinational instruction memory and fills the IF/ID
//              register. Handles redirect > flush > stall > normal.
//              Optional macro IF_ALIGN_CHECK_EN enables the align_err pulse
//              for redirect targets whose low two bits are non-zero.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_cnt,
  output logic        align_err
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        ifid_load;
  logic        ifid_clear;

  // Wraps naturally at 32 bits
  assign pc_plus4  = pc + PC_STEP;
  assign imem_addr = pc;

  // Next-PC and IF/ID control; nothing moves while in BOOT
  always_comb begin
    pc_next    = pc;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    if (state == RUN) begin
      if (redirect_valid) begin
        // Stall is ignored on a redirect edge; low bits are always dropped
        pc_next    = {redirect_pc[31:2], 2'b00};
        ifid_clear = 1'b1;
      end else begin
        ifid_clear = flush;
        if (!stall) begin
          pc_next = pc_plus4;
        end
        ifid_load = !flush && !stall;
      end
    end
  end

  // FSM: BOOT lasts exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= RUN;
    end
  end

  // Program counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= {RESET_PC[31:2], 2'b00};
    end else begin
      pc <= pc_next;
    end
  end

  // Count every instruction actually captured into IF/ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
    end else if (ifid_load) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  // One-cycle pulse after a redirect edge whose target is misaligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err <= 1'b0;
    end else begin
      align_err <= (state == RUN) && redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign align_err = 1'b0;
`endif

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ifid_load),
    .clear   (ifid_clear),
    .inst_in (imem_inst),
    .pc_in   (pc),
    .pc4_in  (pc_plus4),
    .inst    (if_id_inst),
    .pc      (if_id_pc),
    .pc4     (if_id_pc4),
    .valid   (if_id_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module     : tb_if_stage
// Description: Directed, table-driven bench for if_stage. Instruction memory
//              is a combinational function of the address.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_cnt;
  logic        align_err;

  int tests;
  int failed;

`ifdef IF_ALIGN_CHECK_EN
  localparam logic ALIGN_ON = 1'b1;
`else
  localparam logic ALIGN_ON = 1'b0;
`endif

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        aerr;
  } vec_t;

  vec_t vecs[19];

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_inst     (if_id_inst),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid),
    .fetch_cnt      (fetch_cnt),
    .align_err      (align_err)
  );

  // Distinctive word per address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
  endfunction

  assign imem_inst = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic valid,
                         input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic [31:0] cnt, input logic aerr);
    chk({tag, ".imem_addr"}, imem_addr, addr);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, valid});
    chk({tag, ".inst"}, if_id_inst, inst);
    chk({tag, ".pc"}, if_id_pc, pc);
    chk({tag, ".pc4"}, if_id_pc4, pc4);
    chk({tag, ".fetch_cnt"}, fetch_cnt, cnt);
    chk({tag, ".align_err"}, {31'b0, align_err}, {31'b0, aerr});
  endtask

  function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] rpc,
                              input logic [31:0] addr, input logic v, input logic [31:0] inst,
                              input logic [31:0] pc, input logic [31:0] pc4,
                              input logic [31:0] cnt, input logic aerr);
    vec_t x;
    x.stall = s; x.flush = f; x.redir = r; x.rpc = rpc;
    x.addr = addr; x.valid = v; x.inst = inst; x.pc = pc; x.pc4 = pc4;
    x.cnt = cnt; x.aerr = aerr;
    return x;
  endfunction

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    //          stall flush redir rpc           addr          v  inst                    pc            pc4           cnt aerr
    vecs[0]  = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,                 32'h0,        32'h0,        0, 0); // BOOT->RUN
    vecs[1]  = mk(0, 0, 0, 32'h0,        32'h4,        1, mem_word(32'h0),       32'h0,        32'h4,        1, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,        32'h8,        1, mem_word(32'h4),       32'h4,        32'h8,        2, 0);
    vecs[3]  = mk(1, 0, 0, 32'h0,        32'h8,        1, mem_word(32'h4),       32'h4,        32'h8,        2, 0); // stall x3
    vecs[4]  = mk(1, 0, 0, 32'h0,        32'h8,        1, mem_word(32'h4),       32'h4,        32'h8,        2, 0);
    vecs[5]  = mk(1, 0, 0, 32'h0,        32'h8,        1, mem_word(32'h4),       32'h4,        32'h8,        2, 0);
    vecs[6]  = mk(0, 0, 0, 32'h0,        32'hC,        1, mem_word(32'h8),       32'h8,        32'hC,        3, 0);
    vecs[7]  = mk(1, 0, 1, 32'h20,       32'h20,       0, 32'h0,                 32'h0,        32'h0,        3, 0); // redirect+stall
    vecs[8]  = mk(0, 0, 0, 32'h0,        32'h24,       1, mem_word(32'h20),      32'h20,       32'h24,       4, 0);
    vecs[9]  = mk(0, 1, 0, 32'h0,        32'h28,       0, 32'h0,                 32'h0,        32'h0,        4, 0); // flush
    vecs[10] = mk(1, 1, 0, 32'h0,        32'h28,       0, 32'h0,                 32'h0,        32'h0,        4, 0); // flush+stall
    vecs[11] = mk(0, 0, 0, 32'h0,        32'h2C,       1, mem_word(32'h28),      32'h28,       32'h2C,       5, 0);
    vecs[12] = mk(0, 0, 1, 32'h1A,       32'h18,       0, 32'h0,                 32'h0,        32'h0,        5, ALIGN_ON); // misaligned
    vecs[13] = mk(0, 0, 0, 32'h0,        32'h1C,       1, mem_word(32'h18),      32'h18,       32'h1C,       6, 0);
    vecs[14] = mk(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0,               32'h0,        32'h0,        6, 0);
    vecs[15] = mk(0, 0, 0, 32'h0,        32'h0,        1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0,      7, 0); // wrap
    vecs[16] = mk(0, 1, 1, 32'h41,       32'h40,       0, 32'h0,                 32'h0,        32'h0,        7, ALIGN_ON);
    vecs[17] = mk(1, 0, 0, 32'h0,        32'h40,       0, 32'h0,                 32'h0,        32'h0,        7, 0);
    vecs[18] = mk(0, 0, 0, 32'h0,        32'h44,       1, mem_word(32'h40),      32'h40,       32'h44,       8, 0);

    // Reset state while held in reset
    #2;
    chk_all("reset", 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      stall          = vecs[i].stall;
      flush          = vecs[i].flush;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].valid, vecs[i].inst,
              vecs[i].pc, vecs[i].pc4, vecs[i].cnt, vecs[i].aerr);
    end

    // Mid-cycle asynchronous reset: values must change with no clock edge
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 0);

    // Restart: BOOT edge with stall low still must not fetch
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("reboot1", 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("reboot2", 32'h4, 1, mem_word(32'h0), 32'h0, 32'h4, 1, 0);

    // Redirect in the BOOT cycle is ignored
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    chk_all("boot_redir", 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS pipeline. Holds the program counter, drives the byte address into the combinational instruction memory and registers the returned word with its PC into the IF/ID pipeline register for decode. Handles pipeline stall, flush and control-flow redirect from later stages, and keeps a fetch counter for bring-up.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address to instruction memory; always equals current PC.
- imem_inst  in  32  instruction word returned combinationally for imem_addr; bytes already assembled little-endian.
- stall  in  1  hazard stall: hold PC and IF/ID.
- flush  in  1  squash the IF/ID contents (turn them into a bubble).
- redirect_valid  in  1  taken branch/jump: load PC from redirect_pc.
- redirect_pc  in  32  redirect target byte address.
- if_id_inst  out  32  registered instruction; 32'h0 (nop) when invalid.
- if_id_pc  out  32  registered PC of if_id_inst.
- if_id_pc4  out  32  registered PC+4 (link/branch base).
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_cnt  out  32  count of instructions captured into IF/ID.
- align_err  out  1  one-cycle pulse: misaligned redirect target.

## Operation
- Two-state FSM: BOOT, RUN. Reset enters BOOT. BOOT lasts exactly one cycle and always goes to RUN. In BOOT, the PC is not advanced and IF/ID is not loaded.
- In RUN, the per-edge update uses this priority, highest first: redirect_valid, flush, stall, normal.
- Redirect: PC <= {redirect_pc[31:2],2'b00}. IF/ID is cleared to a bubble: inst 0, valid 0, pc/pc4 0. The stall input is ignored on that edge.
- Flush without redirect: IF/ID is cleared to a bubble. The PC still obeys stall: it holds if stall=1, otherwise PC <= PC+4.
- Stall only: PC and all IF/ID fields hold. fetch_cnt holds.
- Normal: PC <= PC+4. IF/ID <= {imem_inst, PC, PC+4, valid=1}. fetch_cnt increments.
- Arithmetic is 32-bit unsigned. PC+4 wraps from 32'hFFFF_FFFC to 0. fetch_cnt wraps from 32'hFFFF_FFFF to 0.
- PC bits [1:0] are always 0.

## Timing
- Reset values: PC=RESET_PC, imem_addr=RESET_PC, if_id_inst=0, if_id_pc=0, if_id_pc4=0, if_id_valid=0, fetch_cnt=0, align_err=0, state=BOOT.
- Latency: the word at address A appears on if_id_inst one edge after imem_addr=A, provided that edge is a normal update.
- After rst_n rises: first edge is BOOT→RUN. The second edge captures the word at RESET_PC, so if_id_valid=1 after the second edge.
- Redirect on edge N: imem_addr=target after edge N. The target instruction is valid in IF/ID after edge N+1, assuming no stall.
- stall, flush and redirect are sampled only at the rising edge. They have no combinational path to any output.
- Asserting rst_n low mid-operation forces all reset values immediately, regardless of the clock. Any in-flight fetch is discarded.

## Configuration
- IF_ALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0]!=0 raises align_err for exactly the cycle after the redirect edge. The PC is still loaded with the word-aligned target.
- IF_ALIGN_CHECK_EN undefined: low bits are dropped silently and align_err is tied to 0. The port is still present.

## Structure
- Shared package: RESET_PC default, NOP_INST=32'h0, PC_STEP=4, and the FSM state enum {BOOT, RUN}.
- One sub-module, if_id_reg, implements the IF/ID register with load, hold and clear controls. The PC/FSM/counter logic stays in if_stage.

## Test plan
- Reset release with RESET_PC=0 and memory words W0, W1, W2 at 0, 4, 8 -> IF/ID shows W0 (pc 0, pc4 4) after edge 2, W1 after edge 3, W2 after edge 4; fetch_cnt=3 after edge 4.
- stall held for 3 edges while PC=8 -> imem_addr stays 8, IF/ID and fetch_cnt unchanged; fetching resumes at 8.
- redirect_valid with redirect_pc=0x20 and stall=1 on the same edge -> PC=0x20, if_id_valid=0 and if_id_inst=0 after that edge; word at 0x20 is valid after the next edge.
- flush alone at PC=4 -> IF/ID is cleared, and PC=8 after that edge.
- With IF_ALIGN_CHECK_EN, redirect to 0x1A -> PC=0x18 and a one-cycle align_err pulse. Without the macro -> PC=0x18 and align_err stays 0.
- PC forced to 0xFFFF_FFFC via redirect -> next PC=0, if_id_pc4=0. rst_n pulsed low mid-stream -> all outputs return to reset values immediately.
